// File: rtl/tmr_mon_pkg.sv
// tmr_mon_pkg: shared types and helpers for the TMR error monitor
package tmr_mon_pkg;
   localparam int N_REPLICA = 3;
   typedef enum logic [1:0] {RS_OK = 2'd0, RS_SUSPECT = 2'd1, RS_FAULTY = 2'd2} replica_state_e;
   typedef enum logic {EVT_FAULTY = 1'b0, EVT_UNCORR = 1'b1} evt_kind_e;
   function automatic logic two_or_more(input logic [N_REPLICA-1:0] m);
      return (m[0] & m[1]) | (m[0] & m[2]) | (m[1] & m[2]);
   endfunction
endpackage

// File: rtl/tmr_err_monitor_if.sv
// tmr_err_monitor_if: valid/ready event channel towards the status consumer
interface tmr_err_monitor_if;
   import tmr_mon_pkg::*;
   logic       evt_valid;
   logic       evt_ready;
   evt_kind_e  evt_kind;
   logic [1:0] evt_replica;
   modport master(output evt_valid, evt_kind, evt_replica, input evt_ready);
   modport slave(input evt_valid, evt_kind, evt_replica, output evt_ready);
endinterface

// File: rtl/tmr_replica_tracker.sv
// tmr_replica_tracker: leaky saturating error counter and OK/SUSPECT/FAULTY classifier for one replica
module tmr_replica_tracker
   import tmr_mon_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int THRESH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             err_i,
   input  logic             leak_i,
   input  logic             clear_i,
   output logic [CNT_W-1:0] cnt_o,
   output replica_state_e   state_o,
   output logic             to_faulty_o
);
   logic [CNT_W-1:0] cnt_nxt;
   replica_state_e   st_nxt;
   // an error and a leak in the same cycle cancel out
   always_comb begin
      cnt_nxt = clear_i ? '0 :
                state_o == RS_FAULTY ? cnt_o :
                (err_i && !leak_i) ? (cnt_o == '1 ? cnt_o : cnt_o + CNT_W'(1)) :
                (leak_i && !err_i && cnt_o != '0) ? cnt_o - CNT_W'(1) : cnt_o;
      st_nxt = clear_i ? RS_OK :
               state_o == RS_FAULTY ? RS_FAULTY :
               cnt_nxt >= CNT_W'(THRESH) ? RS_FAULTY :
               cnt_nxt != '0 ? RS_SUSPECT : RS_OK;
      to_faulty_o = state_o != RS_FAULTY && st_nxt == RS_FAULTY;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_o   <= '0;
         state_o <= RS_OK;
      end else begin
         cnt_o   <= cnt_nxt;
         state_o <= st_nxt;
      end
   end
endmodule

// File: rtl/tmr_err_monitor.sv
// tmr_err_monitor: tracks per-replica voter mismatches, flags FAULTY replicas and
// uncorrectable votes, and reports them on a valid/ready event channel
module tmr_err_monitor
   import tmr_mon_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int THRESH      = 16,
   parameter int LEAK_PERIOD = 1024
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              err_detected_1_i,
   input  logic                              err_detected_2_i,
   input  logic                              err_detected_3_i,
   input  logic                              err_corrected_i,
   input  logic                              err_detected_i,
   input  logic [N_REPLICA-1:0]              clear_i,
   output logic [N_REPLICA-1:0][1:0]         replica_state_o,
   output logic [N_REPLICA-1:0]              faulty_mask_o,
   output logic [N_REPLICA-1:0][CNT_W-1:0]   err_cnt_o,
   output logic                              uncorr_o,
   output logic                              degraded_o,
   tmr_err_monitor_if.master                 evt
);
   localparam int TW = $clog2(LEAK_PERIOD);
   logic [TW-1:0]        timer;
   logic                 leak, unc, hs, any_pend, pend_uncorr;
   logic [N_REPLICA-1:0] err, to_faulty, faulty_nxt, presented, pend_faulty, pend_eff;
   evt_kind_e            sel_kind;
   logic [1:0]           sel_rep;
   assign err  = {err_detected_3_i, err_detected_2_i, err_detected_1_i};
   assign leak = timer == TW'(LEAK_PERIOD - 1);
   assign unc  = err_detected_i && !err_corrected_i;
   assign hs   = evt.evt_valid && evt.evt_ready;
   for (genvar k = 0; k < N_REPLICA; k++) begin : g_rep
      tmr_replica_tracker #(.CNT_W(CNT_W), .THRESH(THRESH)) u_trk (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .err_i      (err[k]),
         .leak_i     (leak),
         .clear_i    (clear_i[k]),
         .cnt_o      (err_cnt_o[k]),
         .state_o    (replica_state_o[k]),
         .to_faulty_o(to_faulty[k])
      );
      assign presented[k]  = evt.evt_valid && evt.evt_kind == EVT_FAULTY && evt.evt_replica == 2'(k);
      assign faulty_nxt[k] = !clear_i[k] && (replica_state_o[k] == RS_FAULTY || to_faulty[k]);
   end
   // a clear may drop a queued fault event, but never one already on the channel
   assign pend_eff = pend_faulty & ~(clear_i & ~presented);
   assign any_pend = pend_uncorr || |pend_eff;
   assign sel_kind = pend_uncorr ? EVT_UNCORR : EVT_FAULTY;
   assign sel_rep  = (pend_uncorr || pend_eff[0]) ? 2'd0 : pend_eff[1] ? 2'd1 : 2'd2;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer           <= '0;
         pend_uncorr     <= 1'b0;
         pend_faulty     <= '0;
         uncorr_o        <= 1'b0;
         faulty_mask_o   <= '0;
         degraded_o      <= 1'b0;
         evt.evt_valid   <= 1'b0;
         evt.evt_kind    <= EVT_FAULTY;
         evt.evt_replica <= '0;
      end else begin
         timer         <= leak ? '0 : timer + TW'(1);
         uncorr_o      <= uncorr_o || unc;
         pend_uncorr   <= (pend_uncorr && !(hs && evt.evt_kind == EVT_UNCORR)) || unc;
         pend_faulty   <= (pend_eff & ~(hs ? presented : '0)) | to_faulty;
         faulty_mask_o <= faulty_nxt;
         degraded_o    <= two_or_more(faulty_nxt);
         if (hs)
            evt.evt_valid <= 1'b0;
         else if (!evt.evt_valid && any_pend) begin
            evt.evt_valid   <= 1'b1;
            evt.evt_kind    <= sel_kind;
            evt.evt_replica <= sel_rep;
         end
      end
   end
endmodule

// File: tb/tb_tmr_err_monitor.sv
// tb_tmr_err_monitor: directed vector table plus hand-written multi-cycle sequences for tmr_err_monitor
module tb_tmr_err_monitor;
   import tmr_mon_pkg::*;
   logic clk = 1'b0;
   logic rst, det, cor, rst2, det2, cor2;
   logic [2:0] err, clr, err2, clr2, mask, mask2;
   logic [2:0][1:0] st, st2;
   logic [2:0][7:0] cnt;
   logic [2:0][3:0] cnt2;
   logic unc, deg, unc2, deg2;
   int pass = 0, total = 0, cyc = 0;
   tmr_err_monitor_if ev();
   tmr_err_monitor_if ev2();
   always #5 clk = ~clk;
   tmr_err_monitor #(.CNT_W(8), .THRESH(16), .LEAK_PERIOD(32)) dut (
      .clk_i(clk), .rst_i(rst), .err_detected_1_i(err[0]), .err_detected_2_i(err[1]),
      .err_detected_3_i(err[2]), .err_corrected_i(cor), .err_detected_i(det), .clear_i(clr),
      .replica_state_o(st), .faulty_mask_o(mask), .err_cnt_o(cnt), .uncorr_o(unc),
      .degraded_o(deg), .evt(ev));
   tmr_err_monitor #(.CNT_W(4), .THRESH(15), .LEAK_PERIOD(32)) dut2 (
      .clk_i(clk), .rst_i(rst2), .err_detected_1_i(err2[0]), .err_detected_2_i(err2[1]),
      .err_detected_3_i(err2[2]), .err_corrected_i(cor2), .err_detected_i(det2), .clear_i(clr2),
      .replica_state_o(st2), .faulty_mask_o(mask2), .err_cnt_o(cnt2), .uncorr_o(unc2),
      .degraded_o(deg2), .evt(ev2));
   typedef struct {
      logic [2:0] err, clr;
      logic       det, cor, rdy;
      logic [7:0] c0, c1, c2;
      logic [1:0] s0, s1, s2;
      logic       v, kind;
      logic [1:0] rep;
      logic       unc, deg;
   } vec_t;
   vec_t vq[$];
   function automatic vec_t mk(logic [2:0] e, logic [2:0] c, logic d, logic co, logic r,
                               logic [7:0] c0, logic [7:0] c1, logic [7:0] c2,
                               logic [1:0] s0, logic [1:0] s1, logic [1:0] s2,
                               logic v, logic kd, logic [1:0] rp, logic u, logic dg);
      vec_t x;
      x.err = e; x.clr = c; x.det = d; x.cor = co; x.rdy = r;
      x.c0 = c0; x.c1 = c1; x.c2 = c2; x.s0 = s0; x.s1 = s1; x.s2 = s2;
      x.v = v; x.kind = kd; x.rep = rp; x.unc = u; x.deg = dg;
      return x;
   endfunction
   // kind/replica only matter while an event is presented
   function automatic logic [63:0] act_vec();
      return {cnt, st, mask, ev.evt_valid, ev.evt_valid ? {ev.evt_kind, ev.evt_replica} : 3'b000, unc, deg};
   endfunction
   function automatic logic [63:0] exp_vec(vec_t x);
      logic [2:0] m;
      m = {x.s2 == RS_FAULTY, x.s1 == RS_FAULTY, x.s0 == RS_FAULTY};
      return {x.c2, x.c1, x.c0, x.s2, x.s1, x.s0, m, x.v, x.v ? {x.kind, x.rep} : 3'b000, x.unc, x.deg};
   endfunction
   task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) $display("FAIL %s: got %h expected %h", name, a, e);
      else pass++;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask
   task automatic do_reset();
      rst = 1'b1; err = '0; clr = '0; det = 1'b0; cor = 1'b0; ev.evt_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      cyc = 0;
   endtask
   task automatic idle_to(input int k);
      while (cyc < k) tick();
   endtask
   task automatic run_vecs(input string tag);
      foreach (vq[i]) begin
         err = vq[i].err; clr = vq[i].clr; det = vq[i].det; cor = vq[i].cor; ev.evt_ready = vq[i].rdy;
         tick();
         chk($sformatf("%s[%0d]", tag, i), act_vec(), exp_vec(vq[i]));
      end
      vq.delete();
      err = '0; clr = '0; det = 1'b0; cor = 1'b0;
   endtask
   initial begin
      rst2 = 1'b1; err2 = '0; clr2 = '0; det2 = 1'b0; cor2 = 1'b0; ev2.evt_ready = 1'b0;
      do_reset();
      rst2 = 1'b0;
      // reset state and long idle
      chk("reset_state", act_vec(), 64'd0);
      idle_to(96);
      chk("idle_3_leak", act_vec(), 64'd0);
      // replica 1 errors for 16 cycles, consumer always ready
      do_reset();
      for (int k = 1; k <= 16; k++)
         vq.push_back(mk(3'b010, 3'b000, 0, 0, 1, 8'd0, 8'(k), 8'd0, RS_OK,
                         k < 16 ? RS_SUSPECT : RS_FAULTY, RS_OK, 0, 0, 2'd0, 0, 0));
      vq.push_back(mk(3'b010, 3'b000, 0, 0, 1, 8'd0, 8'd16, 8'd0, RS_OK, RS_FAULTY, RS_OK, 1, EVT_FAULTY, 2'd1, 0, 0));
      vq.push_back(mk(3'b010, 3'b000, 0, 0, 1, 8'd0, 8'd16, 8'd0, RS_OK, RS_FAULTY, RS_OK, 0, 0, 2'd0, 0, 0));
      vq.push_back(mk(3'b000, 3'b000, 0, 0, 1, 8'd0, 8'd16, 8'd0, RS_OK, RS_FAULTY, RS_OK, 0, 0, 2'd0, 0, 0));
      run_vecs("t2");
      // replica 0 leak-down, leak ticks at cycles 32/64/96/128
      err = 3'b001; tick(); tick(); tick(); err = '0;
      chk("t3_cnt_after_3", {st[0], cnt[0]}, {RS_SUSPECT, 8'd3});
      idle_to(31);
      chk("t3_before_leak", 64'(cnt[0]), 64'd3);
      tick();
      chk("t3_first_leak", 64'(cnt[0]), 64'd2);
      idle_to(63);
      err = 3'b001; tick(); err = '0;
      chk("t3_err_on_leak", 64'(cnt[0]), 64'd2);
      idle_to(96);
      chk("t3_third_leak", {st[0], cnt[0]}, {RS_SUSPECT, 8'd1});
      idle_to(127);
      chk("t3_pre_zero", {st[0], cnt[0]}, {RS_SUSPECT, 8'd1});
      tick();
      chk("t3_back_to_ok", {st[0], cnt[0]}, {RS_OK, 8'd0});
      chk("t3_r1_frozen", {st[1], cnt[1], mask}, {RS_FAULTY, 8'd16, 3'b010});
      // back-pressure, uncorrectable vote, clear of a presented replica
      do_reset();
      for (int k = 1; k <= 16; k++)
         vq.push_back(mk(3'b100, 3'b000, 0, 0, 0, 8'd0, 8'd0, 8'(k), RS_OK, RS_OK,
                         k < 16 ? RS_SUSPECT : RS_FAULTY, 0, 0, 2'd0, 0, 0));
      vq.push_back(mk(3'b000, 3'b000, 1, 1, 0, 8'd0, 8'd0, 8'd16, RS_OK, RS_OK, RS_FAULTY, 1, EVT_FAULTY, 2'd2, 0, 0));
      vq.push_back(mk(3'b000, 3'b000, 1, 0, 0, 8'd0, 8'd0, 8'd16, RS_OK, RS_OK, RS_FAULTY, 1, EVT_FAULTY, 2'd2, 1, 0));
      vq.push_back(mk(3'b000, 3'b000, 0, 0, 0, 8'd0, 8'd0, 8'd16, RS_OK, RS_OK, RS_FAULTY, 1, EVT_FAULTY, 2'd2, 1, 0));
      vq.push_back(mk(3'b000, 3'b000, 1, 0, 0, 8'd0, 8'd0, 8'd16, RS_OK, RS_OK, RS_FAULTY, 1, EVT_FAULTY, 2'd2, 1, 0));
      vq.push_back(mk(3'b000, 3'b000, 0, 0, 0, 8'd0, 8'd0, 8'd16, RS_OK, RS_OK, RS_FAULTY, 1, EVT_FAULTY, 2'd2, 1, 0));
      vq.push_back(mk(3'b000, 3'b100, 0, 0, 0, 8'd0, 8'd0, 8'd0, RS_OK, RS_OK, RS_OK, 1, EVT_FAULTY, 2'd2, 1, 0));
      for (int k = 0; k < 3; k++)
         vq.push_back(mk(3'b000, 3'b000, 0, 0, 0, 8'd0, 8'd0, 8'd0, RS_OK, RS_OK, RS_OK, 1, EVT_FAULTY, 2'd2, 1, 0));
      vq.push_back(mk(3'b000, 3'b000, 0, 0, 1, 8'd0, 8'd0, 8'd0, RS_OK, RS_OK, RS_OK, 0, 0, 2'd0, 1, 0));
      vq.push_back(mk(3'b000, 3'b000, 0, 0, 0, 8'd0, 8'd0, 8'd0, RS_OK, RS_OK, RS_OK, 1, EVT_UNCORR, 2'd0, 1, 0));
      for (int k = 0; k < 3; k++)
         vq.push_back(mk(3'b000, 3'b000, 0, 0, 1, 8'd0, 8'd0, 8'd0, RS_OK, RS_OK, RS_OK, 0, 0, 2'd0, 1, 0));
      run_vecs("t4");
      // two faulty replicas -> degraded, events in priority order, then clear replica 0
      do_reset();
      ev.evt_ready = 1'b1;
      err = 3'b101;
      repeat (15) tick();
      chk("t5_not_yet_degraded", {mask, deg}, {3'b000, 1'b0});
      tick();
      err = '0;
      chk("t5_degraded", {mask, deg, cnt[0], cnt[2], ev.evt_valid}, {3'b101, 1'b1, 8'd16, 8'd16, 1'b0});
      tick();
      chk("t5_evt_r0", {ev.evt_valid, ev.evt_kind, ev.evt_replica}, {1'b1, EVT_FAULTY, 2'd0});
      tick();
      chk("t5_bubble", 64'(ev.evt_valid), 64'd0);
      tick();
      chk("t5_evt_r2", {ev.evt_valid, ev.evt_kind, ev.evt_replica}, {1'b1, EVT_FAULTY, 2'd2});
      tick();
      chk("t5_drained", 64'(ev.evt_valid), 64'd0);
      clr = 3'b001; tick(); clr = '0;
      chk("t5_cleared", {st[0], cnt[0], mask, deg}, {RS_OK, 8'd0, 3'b100, 1'b0});
      // narrow counters: reset mid-burst, then saturation at 15
      rst2 = 1'b1; tick(); rst2 = 1'b0;
      err2 = 3'b001;
      repeat (4) tick();
      det2 = 1'b1; tick(); det2 = 1'b0;
      repeat (5) tick();
      chk("t6_burst", {cnt2[0], st2[0], unc2, ev2.evt_valid, ev2.evt_kind}, {4'd10, RS_SUSPECT, 1'b1, 1'b1, EVT_UNCORR});
      rst2 = 1'b1; det2 = 1'b1; clr2 = 3'b000; tick();
      rst2 = 1'b0; det2 = 1'b0;
      chk("t6_reset_wins", {cnt2, st2, mask2, unc2, deg2, ev2.evt_valid}, 64'd0);
      repeat (14) tick();
      chk("t6_at_14", {cnt2[0], st2[0]}, {4'd14, RS_SUSPECT});
      tick();
      chk("t6_faulty_15", {cnt2[0], st2[0], mask2}, {4'd15, RS_FAULTY, 3'b001});
      repeat (3) tick();
      err2 = '0;
      chk("t6_sat_15", {cnt2[0], st2[0]}, {4'd15, RS_FAULTY});
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
